// File: rtl/i2c_bytectl.sv
// rtl/i2c_bytectl.sv - byte-level I2C master sequencer feeding per-bit commands to bitxmit
module i2c_bytectl #(
  parameter logic [2:0] OP_START = 3'd1,
  parameter logic [2:0] OP_STOP  = 3'd2,
  parameter logic [2:0] OP_WRITE = 3'd3,
  parameter logic [2:0] OP_READ  = 3'd4,
  // bit command encodings; keep in step with bitxmit.h
  parameter logic [2:0] CMDIDLE  = 3'd0,
  parameter logic [2:0] CMDSTART = 3'd1,
  parameter logic [2:0] CMDSTOP  = 3'd2,
  parameter logic [2:0] CMDBIT0  = 3'd3,
  parameter logic [2:0] CMDBIT1  = 3'd4,
  parameter logic [2:0] CMDRBIT  = 3'd5,
  parameter logic [2:0] CMDWAIT  = 3'd6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] op,
  input  logic       op_valid,
  input  logic [7:0] wdata,
  input  logic       rack,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       nack,
  output logic [2:0] bit_cmd,
  input  logic       bit_ready,
  input  logic       sck_in,
  input  logic       sda_in
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t     state, state_nx;
  logic [2:0] op_q;
  logic [7:0] tx, rx;
  logic       rack_q;
  logic [3:0] cnt;
  logic       sck_q, sampled, ack_q;
  logic       legal, accept, advance, finishing, last_bit, take_sample;
  logic [2:0] cur_cmd;

  assign legal = op_valid && ((op == OP_START) || (op == OP_STOP) ||
                              (op == OP_WRITE) || (op == OP_READ));

  assign last_bit = ((op_q == OP_START) || (op_q == OP_STOP)) ? (cnt == 4'd0) : (cnt == 4'd8);

  always_comb begin
    cur_cmd = CMDWAIT;
    if (op_q == OP_START)
      cur_cmd = CMDSTART;
    else if (op_q == OP_STOP)
      cur_cmd = CMDSTOP;
    else if (op_q == OP_WRITE)
      cur_cmd = (cnt == 4'd8) ? CMDRBIT : (tx[7] ? CMDBIT1 : CMDBIT0);
    else if (op_q == OP_READ)
      cur_cmd = (cnt == 4'd8) ? (rack_q ? CMDBIT0 : CMDBIT1) : CMDRBIT;
  end

  always_comb begin
    state_nx  = state;
    bit_cmd   = CMDWAIT;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    advance   = 1'b0;
    finishing = 1'b0;
    case (state)
      IDLE: begin
        if (legal) begin
          accept   = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        busy    = 1'b1;
        bit_cmd = cur_cmd;
        if (bit_ready)
          state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // wait for bitxmit to drop ready so a stale ready cannot retire the next bit
        if (!bit_ready) begin
          if (last_bit) begin
            finishing = 1'b1;
            state_nx  = FINISH;
          end else begin
            advance  = 1'b1;
            state_nx = ISSUE;
          end
        end
      end
      FINISH: begin
        done = 1'b1;
        if (legal) begin
          accept   = 1'b1;
          state_nx = ISSUE;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign take_sample = (state == ISSUE) && (cur_cmd == CMDRBIT) && sck_in && !sck_q && !sampled;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= 3'd0;
      tx      <= 8'h00;
      rx      <= 8'h00;
      rack_q  <= 1'b0;
      cnt     <= 4'd0;
      sck_q   <= 1'b1;
      sampled <= 1'b0;
      ack_q   <= 1'b0;
      rdata   <= 8'h00;
      nack    <= 1'b0;
    end else begin
      state <= state_nx;
      sck_q <= sck_in;
      if (accept) begin
        op_q   <= op;
        tx     <= wdata;
        rack_q <= rack;
        cnt    <= 4'd0;
      end else if (advance) begin
        cnt <= cnt + 4'd1;
        tx  <= {tx[6:0], 1'b0};
      end
      // one sample per bit: the flag is only cleared once ISSUE is left
      if (state != ISSUE) begin
        sampled <= 1'b0;
      end else if (take_sample) begin
        sampled <= 1'b1;
        if (op_q == OP_READ)
          rx <= {rx[6:0], sda_in};
        else
          ack_q <= sda_in;
      end
      if (finishing) begin
        if (op_q == OP_READ)
          rdata <= rx;
        if (op_q == OP_WRITE)
          nack <= ack_q;
      end
    end
  end

endmodule

// File: tb/tb_i2c_bytectl.sv
// tb/tb_i2c_bytectl.sv - randomized self-checking bench for i2c_bytectl with bitxmit and slave models
module tb_i2c_bytectl;

  localparam logic [2:0] OP_START = 3'd1, OP_STOP = 3'd2, OP_WRITE = 3'd3, OP_READ = 3'd4;
  localparam logic [2:0] C_IDLE = 3'd0, C_START = 3'd1, C_STOP = 3'd2, C_BIT0 = 3'd3,
                         C_BIT1 = 3'd4, C_RBIT = 3'd5, C_WAIT = 3'd6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] op = 3'd0;
  logic       op_valid = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       rack = 1'b0;
  logic       busy, done, nack;
  logic [7:0] rdata;
  logic [2:0] bit_cmd;
  logic       bit_ready, sck_in, sda_in;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  i2c_bytectl dut (
    .clk(clk), .reset(reset), .op(op), .op_valid(op_valid), .wdata(wdata), .rack(rack),
    .busy(busy), .done(done), .rdata(rdata), .nack(nack), .bit_cmd(bit_cmd),
    .bit_ready(bit_ready), .sck_in(sck_in), .sda_in(sda_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // bitxmit stand-in: 8-cycle bit with SCK high in the middle, ready handshake, wired-AND SDA with a slave
  logic       bx_run, m_scl, m_sda, s_sda;
  logic [2:0] bx_cmd, bx_cnt;
  logic [2:0] cmd_log[$];
  logic [2:0] exp_q[$];
  logic       slave_q[$];

  assign sck_in = m_scl;
  assign sda_in = m_sda & s_sda;

  always @(posedge clk) begin
    if (reset) begin
      bit_ready <= 1'b0; bx_run <= 1'b0; bx_cnt <= 3'd0; bx_cmd <= C_WAIT;
      m_scl <= 1'b1; m_sda <= 1'b1; s_sda <= 1'b1;
    end else if (bx_run) begin
      bx_cnt <= bx_cnt + 3'd1;
      case (bx_cmd)
        C_START: begin
          if (bx_cnt == 3'd0) begin m_sda <= 1'b1; m_scl <= 1'b1; end
          if (bx_cnt == 3'd3) m_sda <= 1'b0;
          if (bx_cnt == 3'd6) m_scl <= 1'b0;
        end
        C_STOP: begin
          if (bx_cnt == 3'd0) begin m_scl <= 1'b0; m_sda <= 1'b0; end
          if (bx_cnt == 3'd3) m_scl <= 1'b1;
          if (bx_cnt == 3'd6) m_sda <= 1'b1;
        end
        default: begin
          if (bx_cnt == 3'd0) begin m_scl <= 1'b0; m_sda <= (bx_cmd == C_BIT1) || (bx_cmd == C_RBIT); end
          if (bx_cnt == 3'd2) m_scl <= 1'b1;
          if (bx_cnt == 3'd5) m_scl <= 1'b0;
        end
      endcase
      if (bx_cnt == 3'd7) begin bx_run <= 1'b0; bit_ready <= 1'b1; end
    end else if (bit_ready) begin
      if (bit_cmd == C_WAIT) bit_ready <= 1'b0;
    end else if (bit_cmd != C_WAIT && bit_cmd != C_IDLE) begin
      bx_run <= 1'b1; bx_cnt <= 3'd0; bx_cmd <= bit_cmd;
      cmd_log.push_back(bit_cmd);
      if (bit_cmd == C_RBIT && slave_q.size() > 0) s_sda <= slave_q.pop_front();
      else s_sda <= 1'b1;
    end
  end

  int         done_cnt = 0;
  int         idle_cmd_seen = 0;
  logic [7:0] last_rdata = 8'h00;
  logic       last_nack = 1'b0;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1; last_rdata <= rdata; last_nack <= nack;
    end
    if (bit_cmd === C_IDLE) idle_cmd_seen <= idle_cmd_seen + 1;
  end

  // reference: what each op must put on the bit command stream
  task automatic build_expect(input logic [2:0] o, input logic [7:0] wd, input logic rk);
    case (o)
      OP_START: exp_q.push_back(C_START);
      OP_STOP:  exp_q.push_back(C_STOP);
      OP_WRITE: begin
        for (int i = 7; i >= 0; i--) exp_q.push_back(wd[i] ? C_BIT1 : C_BIT0);
        exp_q.push_back(C_RBIT);
      end
      OP_READ: begin
        repeat (8) exp_q.push_back(C_RBIT);
        exp_q.push_back(rk ? C_BIT0 : C_BIT1);
      end
      default: ;
    endcase
  endtask

  task automatic load_slave(input logic [2:0] o, input logic [7:0] sb, input logic sa);
    slave_q.delete();
    if (o == OP_READ) for (int i = 7; i >= 0; i--) slave_q.push_back(sb[i]);
    if (o == OP_WRITE) slave_q.push_back(sa);
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_len"}, 32'(cmd_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cmd_log.size(); i++)
      check($sformatf("%s_cmd%0d", tag, i), 32'(cmd_log[i]), 32'(exp_q[i]));
  endtask

  task automatic wait_done(input int d0, input string tag);
    int n = 0;
    while (done_cnt == d0 && n < 4000) begin @(posedge clk); n++; end
    check({tag, "_timeout"}, 32'(done_cnt == d0), 32'd0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [7:0] wd, input logic rk,
                        input logic [7:0] sb, input logic sa, input string tag);
    int d0;
    exp_q.delete(); build_expect(o, wd, rk); load_slave(o, sb, sa);
    cmd_log.delete(); d0 = done_cnt;
    @(negedge clk); op = o; wdata = wd; rack = rk; op_valid = 1'b1;
    @(negedge clk); op_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(d0, tag);
    repeat (3) @(negedge clk);
    check({tag, "_ndone"}, 32'(done_cnt - d0), 32'd1);
    compare_log(tag);
    if (o == OP_READ) check({tag, "_rdata"}, 32'(last_rdata), 32'(sb));
    if (o == OP_WRITE) check({tag, "_nack"}, 32'(last_nack), 32'(sa));
  endtask

  task automatic run_illegal(input logic [2:0] o, input string tag);
    int d0;
    d0 = done_cnt;
    @(negedge clk); op = o; op_valid = 1'b1;
    @(negedge clk); op_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    check({tag, "_ndone"}, 32'(done_cnt - d0), 32'd0);
  endtask

  initial begin
    int d0, n;
    logic [2:0] ro;
    logic [7:0] rb;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_rdata", 32'(rdata), 32'h00);
    check("rst_nack", 32'(nack), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_cmd", 32'(bit_cmd), 32'(C_WAIT));
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_lines", 32'({sck_in, sda_in}), 32'h3);
    end

    run_op(OP_START, 8'h00, 1'b0, 8'h00, 1'b0, "start");
    run_op(OP_WRITE, 8'hA5, 1'b0, 8'h00, 1'b0, "wr_a5");
    run_op(OP_WRITE, 8'h3C, 1'b0, 8'h00, 1'b1, "wr_3c");
    run_op(OP_READ,  8'h00, 1'b0, 8'hC3, 1'b0, "rd_c3");
    run_op(OP_STOP,  8'h00, 1'b0, 8'h00, 1'b0, "stop");
    check("stop_lines", 32'({sck_in, sda_in}), 32'h3);

    // back-to-back START then WRITE 00, with ignored requests while busy
    exp_q.delete(); build_expect(OP_START, 8'h00, 1'b0); build_expect(OP_WRITE, 8'h00, 1'b0);
    load_slave(OP_WRITE, 8'h00, 1'b0); cmd_log.delete(); d0 = done_cnt;
    @(negedge clk); op = OP_START; op_valid = 1'b1;
    @(negedge clk); op_valid = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    check("b2b_done_seen", 32'(done), 32'd1);
    op = OP_WRITE; wdata = 8'h00; op_valid = 1'b1;
    @(negedge clk); op_valid = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_cmd", 32'(bit_cmd), 32'(C_BIT0));
    op = OP_READ; op_valid = 1'b1;
    @(negedge clk); op = 3'd6;
    @(negedge clk); op_valid = 1'b0;
    repeat (2) @(negedge clk);
    wait_done(d0 + 1, "b2b");
    repeat (3) @(negedge clk);
    check("b2b_ndone", 32'(done_cnt - d0), 32'd2);
    compare_log("b2b");
    check("b2b_nack", 32'(last_nack), 32'd0);

    // reset during bit 4 of a read
    load_slave(OP_READ, 8'h5A, 1'b0); cmd_log.delete(); d0 = done_cnt;
    @(negedge clk); op = OP_READ; rack = 1'b1; op_valid = 1'b1;
    @(negedge clk); op_valid = 1'b0;
    n = 0;
    while (cmd_log.size() < 5 && n < 2000) begin @(posedge clk); n++; end
    check("rst_reach_bit4", 32'(cmd_log.size() >= 5), 32'd1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("mid_rst_cmd", 32'(bit_cmd), 32'(C_WAIT));
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rdata", 32'(rdata), 32'h00);
    check("mid_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    @(posedge clk);
    check("mid_rst_ndone", 32'(done_cnt - d0), 32'd0);

    for (int k = 0; k < 24; k++) begin
      ro = 3'($urandom_range(0, 7));
      rb = 8'($urandom);
      if (ro >= OP_START && ro <= OP_READ)
        run_op(ro, 8'($urandom), 1'($urandom), rb, 1'($urandom), $sformatf("rnd%0d", k));
      else
        run_illegal(ro, $sformatf("ill%0d", k));
    end

    check("never_cmdidle", 32'(idle_cmd_seen), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
